// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin arbiter sharing the register file write port
// between the ALU writeback source (A) and the load writeback source (B).
module wb_port_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_stall,
  input  logic          i_a_valid,
  input  logic [AW-1:0] i_a_rd,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_ready,
  input  logic          i_b_valid,
  input  logic [AW-1:0] i_b_rd,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_ready,
  output logic          o_regwrite,
  output logic [AW-1:0] o_rd,
  output logic [DW-1:0] o_writedata,
  output logic          o_last_src
);

  logic          r_regwrite;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_writedata;
  logic          r_last_src;

  logic          w_grant_a;
  logic          w_grant_b;
  logic [AW-1:0] w_win_rd;
  logic [DW-1:0] w_win_data;

  // On contention the source not named by r_last_src wins, giving strict alternation.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!i_rst && !i_stall) begin
      if (i_a_valid && i_b_valid) begin
        w_grant_a = r_last_src;
        w_grant_b = ~r_last_src;
      end else if (i_a_valid) begin
        w_grant_a = 1'b1;
      end else if (i_b_valid) begin
        w_grant_b = 1'b1;
      end
    end
  end

  always_comb begin
    w_win_rd   = i_a_rd;
    w_win_data = i_a_data;
    if (w_grant_b) begin
      w_win_rd   = i_b_rd;
      w_win_data = i_b_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_regwrite  <= 1'b0;
      r_rd        <= '0;
      r_writedata <= '0;
      r_last_src  <= 1'b1;
    end else if (w_grant_a || w_grant_b) begin
      // Writes to register 0 are consumed but never reach the register file.
      r_regwrite  <= (w_win_rd != '0);
      r_rd        <= w_win_rd;
      r_writedata <= w_win_data;
      r_last_src  <= w_grant_b;
    end else begin
      r_regwrite  <= 1'b0;
    end
  end

  assign o_a_ready   = w_grant_a;
  assign o_b_ready   = w_grant_b;
  assign o_regwrite  = r_regwrite;
  assign o_rd        = r_rd;
  assign o_writedata = r_writedata;
  assign o_last_src  = r_last_src;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed vector table plus randomized run against a
// behavioural write-port model for wb_port_arbiter.
module tb_wb_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, stall;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [AW-1:0] a_rd, b_rd, rd;
  logic [DW-1:0] a_data, b_data, writedata;
  logic          regwrite, last_src;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] rf [32];
  always @(posedge clk) if (regwrite) rf[rd] <= writedata;

  wb_port_arbiter #(.DW(DW), .AW(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall),
    .i_a_valid(a_valid), .i_a_rd(a_rd), .i_a_data(a_data), .o_a_ready(a_ready),
    .i_b_valid(b_valid), .i_b_rd(b_rd), .i_b_data(b_data), .o_b_ready(b_ready),
    .o_regwrite(regwrite), .o_rd(rd), .o_writedata(writedata), .o_last_src(last_src)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          rst, stall;
    logic          av;
    logic [AW-1:0] ard;
    logic [DW-1:0] ad;
    logic          bv;
    logic [AW-1:0] brd;
    logic [DW-1:0] bd;
    logic          ea, eb, erw;
    logic [AW-1:0] erd;
    logic [DW-1:0] ewd;
    logic          elast;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state for the random phase.
  logic          m_rw, m_last;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rf [32];
  bit            m_written [32];

  initial begin
    rst = 1'b1; stall = 1'b0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    @(posedge clk); #1;

    //             rst stall av ard  ad            bv brd  bd            ea eb rw rd  wd            last
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         1});
    tbl.push_back('{0, 0, 1, 3, 32'hDEADBEEF,  0, 0, 32'h0,         1, 0, 1, 3, 32'hDEADBEEF,  0});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         1});
    tbl.push_back('{0, 0, 1, 5, 32'h11111111,  1, 6, 32'h22222222,  1, 0, 1, 5, 32'h11111111,  0});
    tbl.push_back('{0, 0, 1, 5, 32'h11111111,  1, 6, 32'h22222222,  0, 1, 1, 6, 32'h22222222,  1});
    tbl.push_back('{0, 0, 1, 5, 32'h11111111,  1, 6, 32'h22222222,  1, 0, 1, 5, 32'h11111111,  0});
    tbl.push_back('{0, 0, 1, 5, 32'h11111111,  1, 6, 32'h22222222,  0, 1, 1, 6, 32'h22222222,  1});
    tbl.push_back('{0, 0, 0, 0, 32'h0,         1, 0, 32'hFFFFFFFF,  0, 1, 0, 0, 32'hFFFFFFFF,  1});
    tbl.push_back('{0, 1, 1, 5, 32'h33,        1, 6, 32'h44,        0, 0, 0, 0, 32'hFFFFFFFF,  1});
    tbl.push_back('{0, 1, 1, 5, 32'h33,        1, 6, 32'h44,        0, 0, 0, 0, 32'hFFFFFFFF,  1});
    tbl.push_back('{0, 1, 1, 5, 32'h33,        1, 6, 32'h44,        0, 0, 0, 0, 32'hFFFFFFFF,  1});
    tbl.push_back('{0, 0, 1, 5, 32'h33,        1, 6, 32'h44,        1, 0, 1, 5, 32'h33,        0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,         1, 6, 32'h44,        0, 1, 1, 6, 32'h44,        1});
    tbl.push_back('{0, 0, 1, 1, 32'h55,        0, 0, 32'h0,         1, 0, 1, 1, 32'h55,        0});
    tbl.push_back('{0, 0, 1, 7, 32'hAAAA0000,  1, 7, 32'hBBBB0000,  0, 1, 1, 7, 32'hBBBB0000,  1});
    tbl.push_back('{0, 0, 1, 7, 32'hAAAA0000,  0, 0, 32'h0,         1, 0, 1, 7, 32'hAAAA0000,  0});
    tbl.push_back('{1, 0, 0, 0, 32'h0,         1, 9, 32'h99,        0, 0, 0, 0, 32'h0,         1});
    tbl.push_back('{0, 0, 0, 0, 32'h0,         1, 9, 32'h99,        0, 1, 1, 9, 32'h99,        1});

    foreach (tbl[i]) begin
      rst = tbl[i].rst; stall = tbl[i].stall;
      a_valid = tbl[i].av; a_rd = tbl[i].ard; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_rd = tbl[i].brd; b_data = tbl[i].bd;
      #1;
      chk($sformatf("vec%0d a_ready", i), 64'(a_ready), 64'(tbl[i].ea));
      chk($sformatf("vec%0d b_ready", i), 64'(b_ready), 64'(tbl[i].eb));
      @(posedge clk); #1;
      chk($sformatf("vec%0d regwrite", i), 64'(regwrite), 64'(tbl[i].erw));
      chk($sformatf("vec%0d rd", i), 64'(rd), 64'(tbl[i].erd));
      chk($sformatf("vec%0d writedata", i), 64'(writedata), 64'(tbl[i].ewd));
      chk($sformatf("vec%0d last_src", i), 64'(last_src), 64'(tbl[i].elast));
    end
    chk("reg7 final value", 64'(rf[7]), 64'(32'hAAAA0000));

    // Randomized phase: start from reset so the model and DUT share a known state.
    rst = 1'b1; stall = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1;
    m_rw = 1'b0; m_rd = '0; m_wd = '0; m_last = 1'b1;
    for (int r = 0; r < 32; r++) m_written[r] = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      int win;
      bit last_cycle;
      last_cycle = (cyc == 2999);
      rst   = !last_cycle && ($urandom_range(0, 49) == 0);
      stall = !last_cycle && ($urandom_range(0, 3) == 0);
      if (last_cycle) begin
        a_valid = 1'b0; b_valid = 1'b0;
      end else begin
        if (!a_valid && $urandom_range(0, 2) != 0) begin
          a_valid = 1'b1;
          a_rd    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
          a_data  = $urandom;
        end
        if (!b_valid && $urandom_range(0, 2) != 0) begin
          b_valid = 1'b1;
          b_rd    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
          b_data  = $urandom;
        end
      end
      #1;
      // Winner: sole requester, else whichever source did not win last time.
      win = -1;
      if (!rst && !stall) begin
        if (a_valid && b_valid) win = m_last ? 0 : 1;
        else if (a_valid)       win = 0;
        else if (b_valid)       win = 1;
      end
      chk("rand a_ready", 64'(a_ready), 64'(win == 0));
      chk("rand b_ready", 64'(b_ready), 64'(win == 1));
      if (rst) begin
        m_rw = 1'b0; m_rd = '0; m_wd = '0; m_last = 1'b1;
      end else if (win >= 0) begin
        m_rd   = (win == 0) ? a_rd : b_rd;
        m_wd   = (win == 0) ? a_data : b_data;
        m_rw   = (m_rd != 0);
        m_last = (win == 1);
        if (m_rw) begin
          m_rf[m_rd]      = m_wd;
          m_written[m_rd] = 1'b1;
        end
      end else begin
        m_rw = 1'b0;
      end
      @(posedge clk); #1;
      if (win == 0) a_valid = 1'b0;
      if (win == 1) b_valid = 1'b0;
      chk("rand regwrite", 64'(regwrite), 64'(m_rw));
      chk("rand rd", 64'(rd), 64'(m_rd));
      chk("rand writedata", 64'(writedata), 64'(m_wd));
      chk("rand last_src", 64'(last_src), 64'(m_last));
    end

    // One more edge lets the final registered write commit to the captured file.
    rst = 1'b0; stall = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1;
    for (int r = 1; r < 32; r++)
      if (m_written[r]) chk($sformatf("rf[%0d]", r), 64'(rf[r]), 64'(m_rf[r]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
